// File: rtl/async_fifo_pkg.sv
// Shared widths and types for the single-clock FIFO.
// Optional error flags are enabled with the ASYNC_FIFO_ERR_FLAGS_EN macro.
package async_fifo_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [PTR_WIDTH-1:0]  ptr_t;
endpackage

// File: rtl/async_fifo_if.sv
// Producer/consumer bundle for async_fifo; overflow/underflow exist only
// when ASYNC_FIFO_ERR_FLAGS_EN is defined.
interface async_fifo_if;
  import async_fifo_pkg::*;

  // Requests are sampled on every rising edge: a write is taken when wrt_en
  // is high and full is low, a read when rd_en is high and empty is low;
  // anything else is dropped without side effects.
  data_t wrt_data;
  logic  wrt_en;
  logic  rd_en;
  data_t rd_data;
  logic  full;
  logic  empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic  overflow;
  logic  underflow;

  modport master (output wrt_data, wrt_en, rd_en,
                  input  rd_data, full, empty, overflow, underflow);
  modport slave  (input  wrt_data, wrt_en, rd_en,
                  output rd_data, full, empty, overflow, underflow);
`else
  modport master (output wrt_data, wrt_en, rd_en,
                  input  rd_data, full, empty);
  modport slave  (input  wrt_data, wrt_en, rd_en,
                  output rd_data, full, empty);
`endif
endinterface

// File: rtl/async_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write port plus a read
// register that only reloads on an accepted read.
module async_fifo_mem
  import async_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  logic  re,
  input  addr_t raddr,
  output data_t rdata
);
  data_t mem_q [DEPTH];
  data_t rd_data_d;
  data_t rd_data_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;
endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO top: binary pointers with an extra wrap bit, flags and
// optional sticky error flags (ASYNC_FIFO_ERR_FLAGS_EN).
module async_fifo
  import async_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  async_fifo_if.slave bus
);
  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  logic full, empty;
  logic wr_acc, rd_acc;

  // Equal low bits with differing wrap bits means the writer is a lap ahead.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_WIDTH-1] != rptr_q[PTR_WIDTH-1]) &&
                 (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

  assign wr_acc = bus.wrt_en & ~full;
  assign rd_acc = bus.rd_en  & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + PTR_WIDTH'(1);
    if (rd_acc) rptr_d = rptr_q + PTR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  async_fifo_mem u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr_q[ADDR_WIDTH-1:0]),
    .wdata (bus.wrt_data),
    .re    (rd_acc),
    .raddr (rptr_q[ADDR_WIDTH-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.full  = full;
  assign bus.empty = empty;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (bus.wrt_en & full);
    underflow_d = underflow_q | (bus.rd_en  & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: directed vector table, corner sequences and random
// traffic checked against a queue-based reference model.
module tb_async_fifo;
  localparam int W     = 16;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  async_fifo_if bus ();

  async_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q [$];
  logic [W-1:0] rd_m;
  logic         ovf_m;
  logic         unf_m;
  int           n_checks;
  int           n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rd_m  = '0;
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(rd_m));
    check({tag, ".full"},    32'(bus.full),    32'(exp_q.size() == DEPTH));
    check({tag, ".empty"},   32'(bus.empty),   32'(exp_q.size() == 0));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"},  32'(bus.overflow),  32'(ovf_m));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(unf_m));
`endif
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of requests, advances the model across the edge and
  // compares every output 1 time unit after the edge.
  task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
    int sz;
    sz = exp_q.size();
    bus.wrt_en   = we;
    bus.wrt_data = wd;
    bus.rd_en    = re;
    @(posedge clk);
    #1;
    if (we && sz == DEPTH) ovf_m = 1'b1;
    if (re && sz == 0)     unf_m = 1'b1;
    if (re && sz > 0)      rd_m = exp_q.pop_front();
    if (we && sz < DEPTH)  exp_q.push_back(wd);
    check_outputs("step");
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step(1'b0, '0, 1'b1);
  endtask

  typedef struct {
    logic         we;
    logic [W-1:0] wd;
    logic         re;
    logic [W-1:0] exp_rd;
    logic         exp_full;
    logic         exp_empty;
  } vec_t;

  vec_t vecs [6];

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] prev_w;
    logic [W-1:0] w;
    int thr_w, thr_r;

    n_checks = 0;
    n_errors = 0;
    model_reset();
    bus.wrt_en   = 1'b0;
    bus.rd_en    = 1'b0;
    bus.wrt_data = '0;

    // Reset held for 6 cycles
    rst_n = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("reset.empty",   32'(bus.empty),   32'd1);
    check("reset.full",    32'(bus.full),    32'd0);
    check("reset.rd_data", 32'(bus.rd_data), 32'd0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("reset.overflow",  32'(bus.overflow),  32'd0);
    check("reset.underflow", 32'(bus.underflow), 32'd0);
`endif
    rst_n = 1'b1;

    // Directed vectors: single word with rd_en held, and empty simultaneity
    vecs[0] = '{1'b1, 16'd420, 1'b1, 16'd0,   1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'd0,   1'b1, 16'd420, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 16'd0,   1'b1, 16'd420, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'd7,   1'b0, 16'd420, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'd9,   1'b1, 16'd7,   1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'd0,   1'b1, 16'd9,   1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re);
      check($sformatf("vec%0d.rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d.full", i),    32'(bus.full),    32'(vecs[i].exp_full));
      check($sformatf("vec%0d.empty", i),   32'(bus.empty),   32'(vecs[i].exp_empty));
    end

    // Fill with 1..16, then overflow attempts 17..20
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, W'(i), 1'b0);
      check("fill.full", 32'(bus.full), 32'(i == 16));
    end
    for (int i = 17; i <= 20; i++) step(1'b1, W'(i), 1'b0);
    check("overflow.full", 32'(bus.full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("drain.order", 32'(bus.rd_data), 32'(i));
    end
    check("drain.empty", 32'(bus.empty), 32'd1);

    // Boundary: both requests at empty -> write kept, rd_data unchanged
    step(1'b1, 16'd77, 1'b1);
    check("bnd_empty.rd_data", 32'(bus.rd_data), 32'd16);
    check("bnd_empty.empty",   32'(bus.empty),   32'd0);
    for (int i = 0; i < 15; i++) step(1'b1, W'(100 + i), 1'b0);
    check("bnd_full.pre", 32'(bus.full), 32'd1);
    // Both requests at full -> one read, write dropped, full clears
    step(1'b1, 16'd555, 1'b1);
    check("bnd_full.rd_data", 32'(bus.rd_data), 32'd77);
    check("bnd_full.full",    32'(bus.full),    32'd0);
    drain();
    check("bnd_full.last", 32'(bus.rd_data), 32'd114);

    // Rate mismatch: write every cycle, read every 5th
    for (int i = 0; i < 50; i++) step(1'b1, W'(1000 + i), (i % 5) == 4);
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, W'(200 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    bus.wrt_en = 1'b0;
    bus.rd_en  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.empty",   32'(bus.empty),   32'd1);
    check("midrst.full",    32'(bus.full),    32'd0);
    check("midrst.rd_data", 32'(bus.rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs("midrst.hold");

    // Wrap-around streaming: output is input delayed one cycle
    prev_w = '0;
    for (int i = 1; i <= 49; i++) begin
      w = W'(2 * i + 3 * i * i + 5);
      step(1'b1, w, 1'b1);
      check("stream.full", 32'(bus.full), 32'd0);
      if (i > 1) check("stream.delay", 32'(bus.rd_data), 32'(prev_w));
      prev_w = w;
    end
    drain();

    // Random traffic in phases biased toward filling and draining
    for (int p = 0; p < 4; p++) begin
      thr_w = (p % 2 == 0) ? 3 : 1;
      thr_r = (p % 2 == 0) ? 1 : 3;
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 3) < thr_w, W'($urandom), $urandom_range(0, 3) < thr_r);
    end
    drain();
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("final.overflow", 32'(bus.overflow), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
